// File: rtl/master_out_port_if.sv
// Serial bus between the master transmitter and the slave's serial input port.
interface master_out_port_if;
  logic tx_address;
  logic tx_data;
  logic m_valid;
  logic write_enable;
  logic read_enable;
  logic s_ready;

  modport master (
    output tx_address,
    output tx_data,
    output m_valid,
    output write_enable,
    output read_enable,
    input  s_ready
  );

  modport slave (
    input  tx_address,
    input  tx_data,
    input  m_valid,
    input  write_enable,
    input  read_enable,
    output s_ready
  );
endinterface

// File: rtl/master_out_port.sv
// Master-side serial transmitter: shifts address and write bytes MSB first under s_ready.
// Define MASTER_OUT_PARITY_EN to append odd parity after the address and after each data byte.
module master_out_port #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned BURST_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               wr,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [DATA_W-1:0]  wdata,
  input  logic               wdata_valid,
  output logic               wdata_ready,
  output logic               busy,
  output logic               tx_done,
  master_out_port_if.master  bus
);

`ifdef MASTER_OUT_PARITY_EN
  localparam int unsigned ParW = 1;
`else
  localparam int unsigned ParW = 0;
`endif
  localparam int unsigned AddrSrW  = ADDR_W + ParW;
  localparam int unsigned SlotW    = DATA_W + ParW;
  localparam int unsigned MaxXfers = SlotW * ((1 << BURST_W) - 1);
  localparam int unsigned CntW     = $clog2(((MaxXfers > AddrSrW) ? MaxXfers : AddrSrW) + 1);
  localparam int unsigned SlotCntW = $clog2(SlotW);

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

  function automatic logic [AddrSrW-1:0] addr_word(input logic [ADDR_W-1:0] a);
`ifdef MASTER_OUT_PARITY_EN
    return {a, ~^a};
`else
    return a;
`endif
  endfunction

  function automatic logic [SlotW-1:0] data_slot(input logic [DATA_W-1:0] b);
`ifdef MASTER_OUT_PARITY_EN
    return {b, ~^b};
`else
    return b;
`endif
  endfunction

  state_e              state_q;
  logic [AddrSrW-1:0]  addr_sr_q;
  logic [SlotW-1:0]    data_sr_q;
  logic [SlotW-1:0]    buf_q;
  logic                sr_full_q;
  logic                buf_full_q;
  logic [SlotCntW-1:0] slot_cnt_q;
  logic [BURST_W-1:0]  fetch_left_q;
  logic [CntW-1:0]     xfer_left_q;
  logic                we_q;
  logic                re_q;

  logic               in_xfer;
  logic               underrun;
  logic               xfer;
  logic               take;
  logic               slot_end;
  logic [BURST_W-1:0] burst_eff;
  logic [CntW-1:0]    data_xfers;
  logic [CntW-1:0]    total;

  assign in_xfer  = (state_q == StXfer);
  // Active byte exhausted while more bytes are still owed by the master logic.
  assign underrun = in_xfer && !sr_full_q && !buf_full_q && (fetch_left_q != '0);
  assign xfer     = bus.m_valid && bus.s_ready;
  assign take     = wdata_valid && wdata_ready;
  assign slot_end = (slot_cnt_q == SlotCntW'(SlotW - 1));

  assign bus.m_valid      = in_xfer && !underrun;
  assign bus.tx_address   = in_xfer && addr_sr_q[AddrSrW-1];
  assign bus.tx_data      = in_xfer && sr_full_q && data_sr_q[SlotW-1];
  assign bus.write_enable = in_xfer && we_q;
  assign bus.read_enable  = in_xfer && re_q;
  assign wdata_ready      = in_xfer && !buf_full_q && (fetch_left_q != '0);
  assign busy             = (state_q != StIdle);
  assign tx_done          = (state_q == StDone);

  always_comb begin
    burst_eff  = (burst_len == '0) ? BURST_W'(1) : burst_len;
    data_xfers = CntW'(SlotW) * CntW'(burst_eff);
    total      = CntW'(AddrSrW);
    if (wr && (data_xfers > total)) begin
      total = data_xfers;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_sr_q    <= '0;
      data_sr_q    <= '0;
      buf_q        <= '0;
      sr_full_q    <= 1'b0;
      buf_full_q   <= 1'b0;
      slot_cnt_q   <= '0;
      fetch_left_q <= '0;
      xfer_left_q  <= '0;
      we_q         <= 1'b0;
      re_q         <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            addr_sr_q    <= addr_word(addr);
            data_sr_q    <= data_slot(wdata);
            sr_full_q    <= wr;
            buf_full_q   <= 1'b0;
            slot_cnt_q   <= '0;
            fetch_left_q <= wr ? (burst_eff - BURST_W'(1)) : '0;
            xfer_left_q  <= total;
            we_q         <= wr;
            re_q         <= !wr;
            state_q      <= StXfer;
          end
        end
        StXfer: begin
          if (xfer) begin
            addr_sr_q   <= addr_sr_q << 1;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            xfer_left_q <= xfer_left_q - CntW'(1);
            if (xfer_left_q == CntW'(1)) begin
              state_q <= StDone;
            end
          end
          if (take) begin
            fetch_left_q <= fetch_left_q - BURST_W'(1);
          end
          if (!sr_full_q) begin
            // Refill straight into the shifter so the stream resumes on the next cycle.
            if (take) begin
              data_sr_q  <= data_slot(wdata);
              sr_full_q  <= 1'b1;
              slot_cnt_q <= '0;
            end
          end else if (xfer && slot_end) begin
            slot_cnt_q <= '0;
            if (buf_full_q) begin
              data_sr_q  <= buf_q;
              buf_full_q <= 1'b0;
            end else if (take) begin
              data_sr_q <= data_slot(wdata);
            end else begin
              sr_full_q <= 1'b0;
            end
          end else begin
            if (xfer) begin
              data_sr_q  <= data_sr_q << 1;
              slot_cnt_q <= slot_cnt_q + SlotCntW'(1);
            end
            if (take) begin
              buf_q      <= data_slot(wdata);
              buf_full_q <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_master_out_port.sv
// Directed bench for master_out_port: single write, read, burst, back-pressure, underrun, reset.
module tb_master_out_port;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        wr;
  logic [11:0] addr;
  logic [11:0] burst_len;
  logic [7:0]  wdata;
  logic        wdata_valid;
  logic        wdata_ready;
  logic        busy;
  logic        tx_done;

  master_out_port_if bus();

  master_out_port dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .wr          (wr),
    .addr        (addr),
    .burst_len   (burst_len),
    .wdata       (wdata),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .busy        (busy),
    .tx_done     (tx_done),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] outs;
  assign outs = {busy, tx_done, wdata_ready, bus.m_valid, bus.tx_address, bus.tx_data,
                 bus.write_enable, bus.read_enable};

  logic [63:0] cap_a, cap_d;
  logic [15:0] stall_log, under_log;
  logic        busy_first, busy_after;
  int          n_xfer, done_cyc, mv_low, we_cnt, re_cnt, accepted;
  logic [7:0]  bytes [$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Launches one transaction and logs what the bus does; cycle 1 is the cycle after the start edge.
  task automatic run_txn(input logic w, input logic [11:0] a, input logic [11:0] bl,
                         input int stall_from, input int stall_to, input int hold_until,
                         input int poke_cyc);
    int nxt = 1;
    cap_a = '0; cap_d = '0; stall_log = '0; under_log = '0;
    n_xfer = 0; mv_low = 0; we_cnt = 0; re_cnt = 0; accepted = 0; busy_first = 1'b0;
    done_cyc = -1;
    start = 1'b1; wr = w; addr = a; burst_len = bl; wdata = bytes[0];
    wdata_valid = 1'b0; bus.s_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      bus.s_ready = !(cyc >= stall_from && cyc <= stall_to);
      start = (cyc == poke_cyc);
      if (start) begin
        addr = ~a; wr = !w; burst_len = 12'd5;
      end
      wdata_valid = (cyc >= hold_until);
      wdata = (nxt < bytes.size()) ? bytes[nxt] : 8'hEE;
      if (cyc == 1) busy_first = busy;
      if (tx_done) begin
        done_cyc = cyc;
        break;
      end
      if (wdata_valid && wdata_ready) begin
        accepted++;
        nxt++;
      end
      if (bus.write_enable) we_cnt++;
      if (bus.read_enable) re_cnt++;
      if (!bus.m_valid) begin
        mv_low++;
        under_log = {under_log[13:0], bus.m_valid, bus.tx_address};
      end else if (bus.s_ready) begin
        cap_a = {cap_a[62:0], bus.tx_address};
        cap_d = {cap_d[62:0], bus.tx_data};
        n_xfer++;
      end else begin
        stall_log = {stall_log[12:0], bus.m_valid, bus.tx_address, bus.tx_data};
      end
      tick();
    end
    start = 1'b0; wdata_valid = 1'b0; bus.s_ready = 1'b1;
    tick();
    busy_after = busy;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; wr = 1'b1; addr = 12'hFFF; burst_len = 12'd3;
    wdata = 8'hFF; wdata_valid = 1'b1; bus.s_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (outs !== 8'h00) begin
      errors++; $display("FAIL reset_outputs got=%b exp=%b", outs, 8'h00);
    end
    rst = 1'b0; start = 1'b0; wdata_valid = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_write_single;
    bytes = {8'hA6};
    run_txn(1'b1, 12'hB5D, 12'd1, 0, 0, 1, 0);
    checks++;
    if (n_xfer !== 12 || cap_a[11:0] !== 12'hB5D) begin
      errors++; $display("FAIL single_addr got=%0d/%h exp=12/b5d", n_xfer, cap_a[11:0]);
    end
    checks++;
    if (cap_d[11:0] !== 12'hA60) begin
      errors++; $display("FAIL single_data got=%h exp=a60", cap_d[11:0]);
    end
    checks++;
    if (we_cnt !== 1 || re_cnt !== 0) begin
      errors++; $display("FAIL single_enables got we=%0d re=%0d exp we=1 re=0", we_cnt, re_cnt);
    end
    checks++;
    if (done_cyc !== 13 || busy_first !== 1'b1 || busy_after !== 1'b0) begin
      errors++;
      $display("FAIL single_timing got done=%0d busy=%b/%b exp done=13 busy=1/0",
               done_cyc, busy_first, busy_after);
    end
    checks++;
    if (accepted !== 0) begin
      errors++; $display("FAIL single_no_fetch got=%0d exp=0", accepted);
    end
  endtask

  task automatic test_read;
    bytes = {8'h00};
    run_txn(1'b0, 12'h0F0, 12'd4, 0, 0, 1, 0);
    checks++;
    if (n_xfer !== 12 || cap_a[11:0] !== 12'h0F0) begin
      errors++; $display("FAIL read_addr got=%0d/%h exp=12/0f0", n_xfer, cap_a[11:0]);
    end
    checks++;
    if (cap_d !== 64'h0) begin
      errors++; $display("FAIL read_data got=%h exp=0", cap_d);
    end
    checks++;
    if (re_cnt !== 1 || we_cnt !== 0) begin
      errors++; $display("FAIL read_enables got re=%0d we=%0d exp re=1 we=0", re_cnt, we_cnt);
    end
    checks++;
    if (done_cyc !== 13 || busy_after !== 1'b0 || accepted !== 0) begin
      errors++;
      $display("FAIL read_done got done=%0d busy=%b acc=%0d exp 13/0/0",
               done_cyc, busy_after, accepted);
    end
  endtask

  task automatic test_burst;
    bytes = {8'h11, 8'h22, 8'h33};
    run_txn(1'b1, 12'h3C5, 12'd3, 0, 0, 1, 0);
    checks++;
    if (n_xfer !== 24 || cap_d[23:0] !== 24'h112233) begin
      errors++; $display("FAIL burst_data got=%0d/%h exp=24/112233", n_xfer, cap_d[23:0]);
    end
    checks++;
    if (cap_a[23:0] !== 24'h3C5000) begin
      errors++; $display("FAIL burst_addr got=%h exp=3c5000", cap_a[23:0]);
    end
    checks++;
    if (accepted !== 2 || mv_low !== 0) begin
      errors++; $display("FAIL burst_fetch got acc=%0d gaps=%0d exp 2/0", accepted, mv_low);
    end
    checks++;
    if (done_cyc !== 25) begin
      errors++; $display("FAIL burst_done got=%0d exp=25", done_cyc);
    end
  endtask

  task automatic test_back_pressure;
    bytes = {8'hA6};
    run_txn(1'b1, 12'hB5D, 12'd1, 3, 5, 1, 0);
    checks++;
    if (n_xfer !== 12 || cap_a[11:0] !== 12'hB5D || cap_d[11:0] !== 12'hA60) begin
      errors++;
      $display("FAIL bp_sequence got=%0d/%h/%h exp=12/b5d/a60", n_xfer, cap_a[11:0], cap_d[11:0]);
    end
    // Third bit of both streams is 1 and must sit on the lines, valid, for all three stalls.
    checks++;
    if (stall_log !== 16'h01FF) begin
      errors++; $display("FAIL bp_hold got=%h exp=01ff", stall_log);
    end
    checks++;
    if (done_cyc !== 16 || we_cnt !== 1) begin
      errors++; $display("FAIL bp_done got done=%0d we=%0d exp 16/1", done_cyc, we_cnt);
    end
  endtask

  task automatic test_underrun;
    bytes = {8'h5A, 8'hC3};
    run_txn(1'b1, 12'h9EF, 12'd2, 0, 0, 13, 0);
    checks++;
    if (mv_low !== 5) begin
      errors++; $display("FAIL underrun_gap got=%0d exp=5", mv_low);
    end
    checks++;
    if (under_log !== 16'h0155) begin
      errors++; $display("FAIL underrun_addr_freeze got=%h exp=0155", under_log);
    end
    checks++;
    if (n_xfer !== 16 || cap_d[15:0] !== 16'h5AC3 || cap_a[15:0] !== 16'h9EF0) begin
      errors++;
      $display("FAIL underrun_stream got=%0d/%h/%h exp=16/5ac3/9ef0",
               n_xfer, cap_d[15:0], cap_a[15:0]);
    end
    checks++;
    if (done_cyc !== 22 || accepted !== 1) begin
      errors++; $display("FAIL underrun_done got done=%0d acc=%0d exp 22/1", done_cyc, accepted);
    end
  endtask

  task automatic test_reset_mid;
    logic seen_done;
    start = 1'b1; wr = 1'b1; addr = 12'hB5D; burst_len = 12'd1; wdata = 8'hA6;
    wdata_valid = 1'b0; bus.s_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc < 7; cyc++) tick();
    checks++;
    if ({bus.m_valid, bus.tx_address, bus.tx_data} !== 3'b101) begin
      errors++;
      $display("FAIL midrst_bit6 got=%b exp=101", {bus.m_valid, bus.tx_address, bus.tx_data});
    end
    rst = 1'b1;
    tick();
    checks++;
    if (outs !== 8'h00) begin
      errors++; $display("FAIL midrst_outputs got=%b exp=%b", outs, 8'h00);
    end
    rst = 1'b0;
    seen_done = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (tx_done || busy) seen_done = 1'b1;
      tick();
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errors++; $display("FAIL midrst_no_done got=%b exp=0", seen_done);
    end
    bytes = {8'h00};
    run_txn(1'b0, 12'h0F0, 12'd1, 0, 0, 1, 0);
    checks++;
    if (done_cyc !== 13 || cap_a[11:0] !== 12'h0F0 || re_cnt !== 1) begin
      errors++;
      $display("FAIL midrst_restart got done=%0d addr=%h re=%0d exp 13/0f0/1",
               done_cyc, cap_a[11:0], re_cnt);
    end
  endtask

  task automatic test_start_while_busy;
    bytes = {8'hA6};
    run_txn(1'b1, 12'hB5D, 12'd1, 0, 0, 1, 5);
    checks++;
    if (cap_a[11:0] !== 12'hB5D || cap_d[11:0] !== 12'hA60 || n_xfer !== 12) begin
      errors++;
      $display("FAIL busy_start_stream got=%h/%h/%0d exp=b5d/a60/12",
               cap_a[11:0], cap_d[11:0], n_xfer);
    end
    checks++;
    if (done_cyc !== 13 || busy_after !== 1'b0 || re_cnt !== 0) begin
      errors++;
      $display("FAIL busy_start_ignored got done=%0d busy=%b re=%0d exp 13/0/0",
               done_cyc, busy_after, re_cnt);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; wr = 1'b0; addr = '0; burst_len = '0;
    wdata = '0; wdata_valid = 1'b0; bus.s_ready = 1'b1;
    test_reset();
    test_write_single();
    test_read();
    test_burst();
    test_back_pressure();
    test_underrun();
    test_reset_mid();
    test_start_while_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/master_out_port.md
Name: master_out_port

Overview:
- Master-side serial transmitter for the two-wire address/data bus.
- Accepts a read or write request from master control logic.
- Shifts a 12-bit address onto tx_address and, for writes, a stream of 8-bit data bytes onto tx_data, MSB first, in parallel.
- Drives the m_valid / write_enable / read_enable qualifiers and obeys the slave's s_ready back-pressure; it is the transmitting end of the slave's serial input port.

Parameters:
- ADDR_W, 12, address width in bits (serial address length).
- DATA_W, 8, data byte width in bits.
- BURST_W, 12, width of the burst length field.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request strobe; accepted only when busy=0.
- wr  in  1  1=write, 0=read; sampled with start.
- addr  in  ADDR_W  transaction address; sampled with start.
- burst_len  in  BURST_W  write bytes in burst; sampled with start; 0 treated as 1.
- wdata  in  DATA_W  write byte; first byte sampled with start, later bytes via handshake.
- wdata_valid  in  1  later byte available on wdata.
- wdata_ready  out  1  internal byte buffer empty; byte taken when wdata_valid&wdata_ready.
- busy  out  1  transaction in progress.
- tx_done  out  1  one-cycle pulse after the last bit transfers.
- tx_address  out  1  serial address bit.
- tx_data  out  1  serial data bit.
- m_valid  out  1  bits on tx_address/tx_data are valid this cycle.
- write_enable  out  1  write qualifier, held until the first bit transfers.
- read_enable  out  1  read qualifier, held until the first bit transfers.
- s_ready  in  1  slave can accept a bit this cycle.

Behaviour:
- Reset: all outputs 0; state IDLE; counters and buffers cleared.
  - rst has priority over everything.
  - rst mid-transfer aborts the transaction; no tx_done.
- Bit transfer rule: a bit is transferred in a cycle where m_valid=1 and s_ready=1. Counters advance only on a transfer; lines hold otherwise.
- States: IDLE, XFER, DONE.
- IDLE:
  - busy=0.
  - On start: latch addr, wr, burst_len (0→1), byte0=wdata; load address shift register; go to XFER next edge.
- XFER:
  - busy=1.
  - Address bit k (k=0..11) on tx_address = addr[11-k]; after bit 11, tx_address=0.
  - Write: tx_data = byte j bit (7-i), where j=floor(n/8) and n is the data bit index. Bytes are contiguous, with no gap between bytes.
  - Read: tx_data=0; no data bits.
  - write_enable=wr / read_enable=!wr from XFER entry until the first transfer, then 0.
  - Total transfers: max(12, 8*burst_len) for writes; 12 for reads. Address and data counters run together.
  - Buffer: one holding register after the active byte.
    - wdata_ready=1 when the register is empty and bytes remain to be fetched.
    - The register moves to the shift register at the byte boundary transfer.
  - Underrun: if the data shift register is empty and bytes remain unfetched (buffer empty), m_valid=0 and all counters freeze.
    - tx_address also freezes.
    - Resume in the cycle after the byte is accepted.
  - Exit: on the last transfer, go to DONE.
- DONE: tx_done=1, busy=1, m_valid=0; go to IDLE next edge.
- start while busy=1 is ignored.
- Latency: start at edge N → m_valid=1 from cycle N+1. With s_ready stuck at 1 and no underrun:
  - tx_done occurs at cycle N+1+T, where T is the total transfer count.
  - busy falls at N+2+T.
- Outside XFER: tx_address=tx_data=0.
- burst_len counter wrap: the maximum 4095 is supported (32760 data bits); the 15-bit data bit counter does not wrap.

Optional Feature:
- Macro: MASTER_OUT_PARITY_EN.
- When defined:
  - An odd-parity bit is appended after address bit 11 on tx_address (13 address transfers).
  - An odd-parity bit is appended after each data byte on tx_data (9 transfers per byte); byte slots become 9 bits.
  - Total write transfers = max(13, 9*burst_len).
- When undefined: no parity bits; timing as in Behaviour. The slave must be built with the same setting.

Test Plan:
- Write, single byte:
  - Stimulus: addr=0xB5D, wdata=0xA6, burst_len=1, s_ready=1.
  - Required: tx_address shows 1011_0101_1101 over 12 cycles; tx_data shows 1010_0110 then 0000.
  - write_enable high only in the first cycle; tx_done at start+13.
- Read: addr=0x0F0, wr=0 → read_enable high in the first cycle; tx_data=0 throughout; 12 transfers; tx_done pulse.
- Burst of 3:
  - Stimulus: bytes 0x11, 0x22, 0x33, wdata_valid always 1.
  - Required: 24 contiguous data bits; wdata_ready accepts exactly 2 bytes; tx_done at start+25.
- Back-pressure:
  - Stimulus: s_ready low for cycles 3-5 of the write in the single-byte test.
  - Required: lines hold bit 3 through the stall; output sequence identical; tx_done delayed by 3.
- Underrun and reset:
  - Stimulus: burst_len=2 with byte 2 withheld until 5 cycles after byte 1 ends.
  - Required: m_valid=0 for 5 cycles, then the stream resumes.
  - Separately: rst asserted at bit 6 → all outputs 0 next cycle, no tx_done, and a new start works.
- start while busy: pulse start during a transfer → ignored; latched addr unchanged.
